// File: rtl/mem_io_responder_if.sv
// CPU byte-bus and UART byte-stream signals that connect to mem_io_responder.
// The master modport is the CPU/host side; the slave modport is the responder.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halted;

    modport master (
        output cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        input  cpu_din, io_buffer_full, tx_data, tx_valid, halted
    );

    modport slave (
        input  cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        output cpu_din, io_buffer_full, tx_data, tx_valid, halted
    );
endinterface

// File: rtl/mem_io_responder.sv
// CPU bus responder: byte RAM, UART TX/RX queues, cycle counter and program-stop sequencer.
// Read data is registered (one-cycle latency); writes take effect at the same edge.
module mem_io_responder #(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input logic               clk_in,
    input logic               rst_in,
    mem_io_responder_if.slave bus_io
);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned TxCw = TxAw + 1;
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned RxCw = RxAw + 1;
    localparam logic [18:0] RamLimit = 19'(64'd1 << RAM_AW);
    localparam logic [17:0] AddrTx   = 18'h30000;
    localparam logic [17:0] AddrStop = 18'h30004;

    typedef enum logic [1:0] {StRun, StStopPush, StDrain, StStopped} state_e;

    // Address decode
    logic [17:0]       addr;
    logic              unused_addr_hi;
    logic              is_io, is_ram, is_tx_reg, is_stop, is_cyc, rd_en, wr_en;
    logic [RAM_AW-1:0] ram_idx;

    assign addr           = bus_io.cpu_a[17:0];
    assign unused_addr_hi = ^bus_io.cpu_a[31:18];
    assign is_io          = addr[17:16] == 2'b11;
    assign is_ram         = !is_io && ({1'b0, addr} < RamLimit);
    assign is_tx_reg      = addr == AddrTx;
    assign is_stop        = addr == AddrStop;
    assign is_cyc         = addr[17:2] == AddrStop[17:2];
    assign wr_en          = bus_io.cpu_wr;
    assign rd_en          = !bus_io.cpu_wr;
    assign ram_idx        = addr[RAM_AW-1:0];

    // Declarations shared by FSM and FIFOs
    state_e          state_q, state_d;
    logic            run, term_push, cnt_en, stopped;
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_wr_q, tx_rd_q;
    logic [TxCw-1:0] tx_cnt_q, tx_cnt_d;
    logic            tx_full, tx_valid, tx_pop, tx_push, cpu_tx_req, tx_ovf_q, tx_ovf_d;
    logic [7:0]      tx_push_data;
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_wr_q, rx_rd_q;
    logic [RxCw-1:0] rx_cnt_q, rx_cnt_d;
    logic            rx_full, rx_pop, rx_push;
    logic [7:0]      cpu_din_q, cpu_din_d;
    logic [31:0]     cyc_cnt_q, cyc_cnt_d, cyc_snap_q, cyc_snap_d;

    // RAM contents are deliberately left unreset
    logic [7:0] ram_q [2**RAM_AW];

    always_ff @(posedge clk_in) begin
        if (wr_en && is_ram) ram_q[ram_idx] <= bus_io.cpu_dout;
    end

    // Stop FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= StRun;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:      if (wr_en && is_stop) state_d = StStopPush;
            StStopPush: if (!tx_full) state_d = StDrain;
            StDrain:    if (tx_cnt_q == '0) state_d = StStopped;
            StStopped:  state_d = StStopped;
            default:    state_d = StRun;
        endcase
    end

    always_comb begin
        run       = 1'b0;
        term_push = 1'b0;
        cnt_en    = 1'b1;
        stopped   = 1'b0;
        case (state_q)
            StRun:      run = 1'b1;
            StStopPush: term_push = !tx_full;
            StStopped: begin
                cnt_en  = 1'b0;
                stopped = 1'b1;
            end
            default: ;
        endcase
    end

    // TX FIFO; a push into a full FIFO is accepted when the head leaves at the same edge
    assign tx_full      = tx_cnt_q == TxCw'(TX_DEPTH);
    assign tx_valid     = tx_cnt_q != '0;
    assign tx_pop       = tx_valid && bus_io.tx_ready;
    assign cpu_tx_req   = run && wr_en && is_tx_reg && (bus_io.cpu_dout != 8'h00);
    assign tx_push      = term_push || (cpu_tx_req && (!tx_full || tx_pop));
    assign tx_push_data = term_push ? 8'h00 : bus_io.cpu_dout;
    assign tx_ovf_d     = tx_ovf_q || (cpu_tx_req && tx_full && !tx_pop);

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TxCw'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TxCw'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
            tx_cnt_q <= tx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= tx_push_data;
    end

    // RX FIFO
    assign rx_full = rx_cnt_q == RxCw'(RX_DEPTH);
    assign rx_pop  = rd_en && is_tx_reg && (rx_cnt_q != '0);
    assign rx_push = bus_io.rx_valid && (!rx_full || rx_pop);

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RxCw'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RxCw'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxAw'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= bus_io.rx_data;
    end

    // Read mux; byte 0 of the counter window takes the snapshot the other bytes return
    always_comb begin
        cpu_din_d  = cpu_din_q;
        cyc_snap_d = cyc_snap_q;
        if (rd_en) begin
            cpu_din_d = 8'h00;
            if (is_ram) begin
                cpu_din_d = ram_q[ram_idx];
            end else if (is_tx_reg) begin
                if (rx_pop) cpu_din_d = rx_mem_q[rx_rd_q];
            end else if (is_cyc) begin
                case (addr[1:0])
                    2'd0: begin
                        cpu_din_d  = cyc_cnt_q[7:0];
                        cyc_snap_d = cyc_cnt_q;
                    end
                    2'd1:    cpu_din_d = cyc_snap_q[15:8];
                    2'd2:    cpu_din_d = cyc_snap_q[23:16];
                    default: cpu_din_d = cyc_snap_q[31:24];
                endcase
            end
        end
    end

    assign cyc_cnt_d = cnt_en ? cyc_cnt_q + 32'd1 : cyc_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_din_q  <= 8'h00;
            cyc_cnt_q  <= 32'd0;
            cyc_snap_q <= 32'd0;
        end else begin
            cpu_din_q  <= cpu_din_d;
            cyc_cnt_q  <= cyc_cnt_d;
            cyc_snap_q <= cyc_snap_d;
        end
    end

    assign bus_io.cpu_din        = cpu_din_q;
    assign bus_io.io_buffer_full = tx_cnt_q >= TxCw'(TX_DEPTH - 2);
    assign bus_io.tx_valid       = tx_valid;
    assign bus_io.tx_data        = tx_valid ? tx_mem_q[tx_rd_q] : 8'h00;
    assign bus_io.halted         = stopped;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed steps plus a random phase, every cycle compared
// against a queue-based reference model of the bus responder.
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_io_responder_if bus_if ();

    mem_io_responder #(
        .RAM_AW  (17),
        .TX_DEPTH(16),
        .RX_DEPTH(16)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus_io(bus_if)
    );

    localparam int Depth = 16;
    typedef enum int {MRun, MStopPush, MDrain, MStopped} mstate_e;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mram [logic [17:0]];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [31:0] mcyc;
    logic [31:0] msnap;
    logic [7:0]  mdin;
    mstate_e     mst;
    logic [17:0] pool [4] = '{18'h00000, 18'h00123, 18'h1FFFF, 18'h0ABCD};
    logic [17:0] other [3] = '{18'h2FFFF, 18'h30008, 18'h3FFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the inputs presented before it
    task automatic model_edge();
        logic [17:0] a;
        bit          io, ram_hit, tx_pop, rx_pop;
        int          tx_n, rx_n;
        mstate_e     nst;
        if (rst) begin
            txq.delete();
            rxq.delete();
            mcyc  = 0;
            msnap = 0;
            mdin  = 0;
            mst   = MRun;
            return;
        end
        a       = bus_if.cpu_a[17:0];
        io      = a[17:16] == 2'b11;
        ram_hit = !io && (a < 18'h20000);
        tx_n    = txq.size();
        rx_n    = rxq.size();
        tx_pop  = (tx_n > 0) && bus_if.tx_ready;
        rx_pop  = 0;
        nst     = mst;
        if (tx_pop) void'(txq.pop_front());
        if (!bus_if.cpu_wr) begin
            if (ram_hit) mdin = mram[a];
            else if (a == 18'h30000) begin
                if (rx_n > 0) begin
                    mdin   = rxq.pop_front();
                    rx_pop = 1;
                end else mdin = 0;
            end else if (a == 18'h30004) begin
                mdin  = mcyc[7:0];
                msnap = mcyc;
            end else if (a >= 18'h30005 && a <= 18'h30007) begin
                mdin = 8'(msnap >> (8 * (a - 18'h30004)));
            end else mdin = 0;
        end else begin
            if (ram_hit) mram[a] = bus_if.cpu_dout;
            if (mst == MRun && a == 18'h30000 && bus_if.cpu_dout != 0) begin
                if (tx_n < Depth || tx_pop) txq.push_back(bus_if.cpu_dout);
            end
            if (mst == MRun && a == 18'h30004) nst = MStopPush;
        end
        if (mst == MStopPush && tx_n < Depth) begin
            txq.push_back(8'h00);
            nst = MDrain;
        end
        if (mst == MDrain && tx_n == 0) nst = MStopped;
        if (bus_if.rx_valid && (rx_n < Depth || rx_pop)) rxq.push_back(bus_if.rx_data);
        if (mst != MStopped) mcyc++;
        mst = nst;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cpu_din", bus_if.cpu_din, mdin);
        chk("tx_valid", bus_if.tx_valid, txq.size() != 0);
        chk("tx_data", bus_if.tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
        chk("io_buffer_full", bus_if.io_buffer_full, txq.size() >= Depth - 2);
        chk("halted", bus_if.halted, mst == MStopped);
    endtask

    task automatic op(input logic [31:0] a, input bit wr, input logic [7:0] d);
        bus_if.cpu_a    = a;
        bus_if.cpu_wr   = wr;
        bus_if.cpu_dout = d;
        step();
        bus_if.cpu_a    = 32'h2FFFF;
        bus_if.cpu_wr   = 1'b0;
        bus_if.cpu_dout = 8'h00;
    endtask

    task automatic drain_tx();
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 64 && txq.size() != 0; i++) step();
        chk("tx_drained", bus_if.tx_valid, 1'b0);
        bus_if.tx_ready = 1'b0;
    endtask

    initial begin
        bus_if.cpu_a    = 32'h2FFFF;
        bus_if.cpu_wr   = 1'b0;
        bus_if.cpu_dout = 8'h00;
        bus_if.tx_ready = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_cpu_din", bus_if.cpu_din, 8'h00);
        chk("rst_tx_valid", bus_if.tx_valid, 1'b0);
        chk("rst_tx_data", bus_if.tx_data, 8'h00);
        chk("rst_io_full", bus_if.io_buffer_full, 1'b0);
        chk("rst_halted", bus_if.halted, 1'b0);

        // RAM round trip, hole, upper address bits ignored
        op(32'h00123, 1, 8'hA5);
        op(32'h00123, 0, 8'h00);
        chk("ram_roundtrip", bus_if.cpu_din, 8'hA5);
        op(32'h2FFFF, 1, 8'h5A);
        op(32'h2FFFF, 0, 8'h00);
        chk("hole_read", bus_if.cpu_din, 8'h00);
        op(32'h00000, 1, 8'h11);
        op(32'h1FFFF, 1, 8'h22);
        op(32'h0ABCD, 1, 8'h33);
        op(32'hFFFC0123, 0, 8'h00);
        chk("ram_hi_bits", bus_if.cpu_din, 8'hA5);
        op(32'h1FFFF, 0, 8'h00);
        chk("ram_top", bus_if.cpu_din, 8'h22);

        // TX path with the UART stalled
        op(32'h30000, 1, 8'h41);
        op(32'h30000, 1, 8'h00);
        op(32'h30000, 1, 8'h42);
        chk("tx_head", bus_if.tx_data, 8'h41);
        for (int i = 0; i < 11; i++) op(32'h30000, 1, 8'(8'h43 + i));
        chk("tx13_not_full", bus_if.io_buffer_full, 1'b0);
        op(32'h30000, 1, 8'h4E);
        chk("tx14_full", bus_if.io_buffer_full, 1'b1);
        op(32'h30000, 1, 8'h4F);
        op(32'h30000, 1, 8'h50);
        op(32'h30000, 1, 8'h51);
        chk("tx_overflow", dut.tx_ovf_q, 1'b1);
        bus_if.tx_ready = 1'b1;
        step();
        chk("tx_second", bus_if.tx_data, 8'h42);
        drain_tx();

        // RX path
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h31;
        step();
        bus_if.rx_data  = 8'h32;
        step();
        bus_if.rx_valid = 1'b0;
        op(32'h30000, 0, 8'h00);
        chk("rx_first", bus_if.cpu_din, 8'h31);
        op(32'h30000, 0, 8'h00);
        chk("rx_second", bus_if.cpu_din, 8'h32);
        op(32'h30000, 0, 8'h00);
        chk("rx_empty", bus_if.cpu_din, 8'h00);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h33;
        step();
        bus_if.rx_data  = 8'h34;
        op(32'h30000, 0, 8'h00);
        chk("rx_push_pop", bus_if.cpu_din, 8'h33);
        bus_if.rx_valid = 1'b0;
        op(32'h30000, 0, 8'h00);
        chk("rx_after_pp", bus_if.cpu_din, 8'h34);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h35;
        op(32'h30000, 0, 8'h00);
        chk("rx_pp_empty", bus_if.cpu_din, 8'h00);
        bus_if.rx_valid = 1'b0;
        op(32'h30000, 0, 8'h00);
        chk("rx_kept", bus_if.cpu_din, 8'h35);

        // Counter snapshot at 0x000001FF
        for (int i = 0; i < 1000 && mcyc != 32'h1FF; i++) step();
        op(32'h30004, 0, 8'h00);
        chk("cyc_b0", bus_if.cpu_din, 8'hFF);
        op(32'h30005, 0, 8'h00);
        chk("cyc_b1", bus_if.cpu_din, 8'h01);
        op(32'h30006, 0, 8'h00);
        chk("cyc_b2", bus_if.cpu_din, 8'h00);
        op(32'h30007, 0, 8'h00);
        chk("cyc_b3", bus_if.cpu_din, 8'h00);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] hi;
            logic [17:0] a;
            logic [7:0]  d;
            int          r;
            bit          w;
            hi = $urandom();
            d  = 8'($urandom());
            r  = $urandom_range(0, 9);
            w  = 0;
            case (r)
                0, 1: begin
                    a = pool[$urandom_range(0, 3)];
                    w = 1;
                end
                2, 3: a = pool[$urandom_range(0, 3)];
                4: begin
                    a = 18'h30000;
                    w = 1;
                    if ($urandom_range(0, 3) == 0) d = 8'h00;
                end
                5: a = 18'h30000;
                6: a = 18'h30004 + 18'($urandom_range(0, 3));
                7: begin
                    a = other[$urandom_range(0, 2)];
                    w = 1'($urandom_range(0, 1));
                end
                default: a = 18'h2FFFF;
            endcase
            bus_if.rx_valid = ($urandom_range(0, 2) == 0);
            bus_if.rx_data  = 8'($urandom());
            bus_if.tx_ready = 1'($urandom_range(0, 1));
            op({hi[31:18], a}, w, d);
        end
        bus_if.rx_valid = 1'b0;

        // Stop with a full TX FIFO
        drain_tx();
        for (int i = 0; i < 16; i++) op(32'h30000, 1, 8'(8'h60 + i));
        op(32'h30004, 1, 8'h00);
        step();
        step();
        step();
        chk("stop_wait_valid", bus_if.tx_valid, 1'b1);
        chk("stop_wait_halt", bus_if.halted, 1'b0);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 60 && mst != MStopped; i++) step();
        chk("stop_halted", bus_if.halted, 1'b1);
        chk("stop_tx_empty", bus_if.tx_valid, 1'b0);
        op(32'h30000, 1, 8'h77);
        chk("stopped_tx_ignored", bus_if.tx_valid, 1'b0);
        op(32'h30004, 0, 8'h00);
        step();
        step();
        op(32'h30004, 0, 8'h00);

        // Reset in the middle of DRAIN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.tx_ready = 1'b0;
        op(32'h30000, 1, 8'h70);
        op(32'h30000, 1, 8'h71);
        op(32'h30004, 1, 8'h00);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tx_valid", bus_if.tx_valid, 1'b0);
        chk("mid_rst_halted", bus_if.halted, 1'b0);
        op(32'h30004, 0, 8'h00);
        chk("mid_rst_cyc", bus_if.cpu_din, 8'h00);
        op(32'h30000, 1, 8'h55);
        chk("mid_rst_run", bus_if.tx_data, 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
